// File: rtl/frame_update_scheduler.sv
// frame_update_scheduler
// Latches game-state positions (ball, left paddle, right paddle) into shadow registers at most
// once per vertical-blanking interval. The pixel generator therefore sees positions that stay
// stable for a whole frame.
//
// Ports:
//   i_clk            system/pixel clock, all logic on its rising edge
//   i_rst            synchronous active-low reset
//   i_vblank         vertical blanking level from the VGA driver (1 = blanking)
//   i_upd_valid      game logic offers a position set
//   o_upd_ready      offered set is accepted this cycle (registered state only)
//   i_ball_pos_in    offered ball position (opaque word)
//   i_left_pad_in    offered left paddle position
//   i_right_pad_in   offered right paddle position
//   o_ball_pos_out   committed ball position
//   o_left_pad_out   committed left paddle position
//   o_right_pad_out  committed right paddle position
//   o_frame_start    one-cycle pulse at the start of each blanking interval
//   o_frame_count    count of blanking intervals (wraps)
//   o_update_missed  one-cycle pulse when a blanking interval ends without a commit
module frame_update_scheduler #(
   parameter int unsigned GUARD_CYCLES = 2,
   parameter int unsigned FRAME_CNT_W  = 16,
   parameter logic [31:0] BALL_INIT    = 32'h0140_00F0,
   parameter logic [31:0] LPAD_INIT    = 32'h0010_00F0,
   parameter logic [31:0] RPAD_INIT    = 32'h0270_00F0
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_vblank,
   input  logic                   i_upd_valid,
   output logic                   o_upd_ready,
   input  logic [31:0]            i_ball_pos_in,
   input  logic [31:0]            i_left_pad_in,
   input  logic [31:0]            i_right_pad_in,
   output logic [31:0]            o_ball_pos_out,
   output logic [31:0]            o_left_pad_out,
   output logic [31:0]            o_right_pad_out,
   output logic                   o_frame_start,
   output logic [FRAME_CNT_W-1:0] o_frame_count,
   output logic                   o_update_missed
);

   // Guard counter only needs to reach GUARD_CYCLES-1.
   localparam int unsigned GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

   typedef enum logic [1:0] {
      StActive,
      StGuard,
      StOpen,
      StClosed
   } state_e;

   state_e                 r_state;
   state_e                 w_state_d;
   logic                   r_vblank_q;
   logic [GW-1:0]          r_guard_cnt;
   logic [GW-1:0]          w_guard_cnt_d;
   logic [31:0]            r_ball;
   logic [31:0]            r_lpad;
   logic [31:0]            r_rpad;
   logic [FRAME_CNT_W-1:0] r_frame_count;
   logic                   r_frame_start;
   logic                   r_missed;

   logic w_rise;
   logic w_guard_done;
   logic w_commit;
   logic w_missed_d;
   logic w_frame_start_d;

   assign w_rise       = i_vblank & ~r_vblank_q;
   assign w_guard_done = (r_guard_cnt == GW'(GUARD_CYCLES - 1));

   always_comb begin
      w_state_d       = r_state;
      w_guard_cnt_d   = r_guard_cnt;
      w_commit        = 1'b0;
      w_missed_d      = 1'b0;
      w_frame_start_d = 1'b0;
      case (r_state)
         StActive: begin
            if (w_rise) begin
               w_frame_start_d = 1'b1;
               w_guard_cnt_d   = '0;
               w_state_d       = (GUARD_CYCLES == 0) ? StOpen : StGuard;
            end
         end
         StGuard: begin
            // Blanking ending during the guard wins over guard completion: no window is opened
            // in a cycle that is already outside blanking.
            if (!i_vblank) begin
               w_state_d  = StActive;
               w_missed_d = 1'b1;
            end else if (w_guard_done) begin
               w_state_d = StOpen;
            end else begin
               w_guard_cnt_d = r_guard_cnt + GW'(1);
            end
         end
         StOpen: begin
            // A transfer beats a simultaneous vblank fall.
            if (i_upd_valid) begin
               w_commit  = 1'b1;
               w_state_d = StClosed;
            end else if (!i_vblank) begin
               w_state_d  = StActive;
               w_missed_d = 1'b1;
            end
         end
         StClosed: begin
            if (!i_vblank) begin
               w_state_d = StActive;
            end
         end
         default: w_state_d = StActive;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state       <= StActive;
         // Reset as "already blanking" so a reset inside blanking does not count a rise.
         r_vblank_q    <= 1'b1;
         r_guard_cnt   <= '0;
         r_ball        <= BALL_INIT;
         r_lpad        <= LPAD_INIT;
         r_rpad        <= RPAD_INIT;
         r_frame_count <= '0;
         r_frame_start <= 1'b0;
         r_missed      <= 1'b0;
      end else begin
         r_state       <= w_state_d;
         r_vblank_q    <= i_vblank;
         r_guard_cnt   <= w_guard_cnt_d;
         r_frame_start <= w_frame_start_d;
         r_missed      <= w_missed_d;
         if (w_frame_start_d) begin
            r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
         end
         if (w_commit) begin
            r_ball <= i_ball_pos_in;
            r_lpad <= i_left_pad_in;
            r_rpad <= i_right_pad_in;
         end
      end
   end

   assign o_upd_ready     = (r_state == StOpen);
   assign o_ball_pos_out  = r_ball;
   assign o_left_pad_out  = r_lpad;
   assign o_right_pad_out = r_rpad;
   assign o_frame_start   = r_frame_start;
   assign o_frame_count   = r_frame_count;
   assign o_update_missed = r_missed;

endmodule
